// File: rtl/nor_stimulus_sequencer_pkg.sv
// Shared types and helpers for the NOR gate stimulus sequencer.
// Optional feature macro used by this slice: NOR_SEQ_LOOP_EN.
package nor_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    // Number of input vectors swept for a 2-input gate.
    localparam int VEC_COUNT = 4;

    // Golden NOR response for one input vector.
    function automatic logic nor_expected(logic a, logic b);
        return ~(a | b);
    endfunction

endpackage

// File: rtl/nor_stimulus_sequencer_if.sv
// Handshake, gate-drive and result bundle of the NOR stimulus sequencer.
// NOR_SEQ_LOOP_EN adds the `loop` request line.
interface nor_stimulus_sequencer_if;
    logic       start;
`ifdef NOR_SEQ_LOOP_EN
    logic       loop;
`endif
    logic       o_a;
    logic       o_b;
    logic       i_c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    // Sequencer side.
    modport master (
        input  start,
`ifdef NOR_SEQ_LOOP_EN
        input  loop,
`endif
        input  i_c,
        output o_a,
        output o_b,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec
    );

    // Requester / gate side.
    modport slave (
        output start,
`ifdef NOR_SEQ_LOOP_EN
        output loop,
`endif
        output i_c,
        input  o_a,
        input  o_b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec
    );
endinterface

// File: rtl/nor_stimulus_sequencer_dwell_counter.sv
// Dwell counter: counts enabled cycles and flags the last cycle of each dwell.
module dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             last
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == (limit - ONE));

    // Next count: clear wins, otherwise wrap after the last dwell cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : (cnt_q + ONE);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/nor_stimulus_sequencer.sv
// NOR gate self-test sequencer: sweeps {a,b} through 00..11, holds each vector
// for DWELL cycles, samples c on the last dwell cycle and reports the results.
// Build option: NOR_SEQ_LOOP_EN (loop=1 in DONE restarts a sweep immediately).
module nor_stimulus_sequencer
    import nor_seq_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    nor_stimulus_sequencer_if.master bus
);
    if (DWELL < 1 || DWELL >= (2 ** CNT_W)) begin : g_bad_dwell
        $fatal(1, "nor_stimulus_sequencer: DWELL=%0d out of range for CNT_W=%0d", DWELL, CNT_W);
    end

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(DWELL);
    localparam logic [1:0]       LAST_IDX = 2'(VEC_COUNT - 1);

    seq_state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] ab_q, ab_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fv_q, fv_d;
    logic       pass_q, pass_d;
    logic       cnt_clr, cnt_en, cnt_last;
    logic       loop_go, launch, sample, last_vec, mismatch;

`ifdef NOR_SEQ_LOOP_EN
    assign loop_go = bus.loop;
`else
    assign loop_go = 1'b0;
`endif

    // A sweep begins on an accepted start, or on a loop request in DONE.
    assign launch   = ((state_q == IDLE) && bus.start) || ((state_q == DONE) && loop_go);
    assign sample   = (state_q == DRIVE) && cnt_last;
    assign last_vec = (idx_q == LAST_IDX);
    assign mismatch = (bus.i_c != nor_expected(ab_q[1], ab_q[0]));

    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (LIMIT),
        .last  (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = DRIVE;
            DRIVE:   if (sample && last_vec) state_d = DONE;
            DONE:    state_d = loop_go ? DRIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs and counter control; the counter is held at zero outside DRIVE.
    always_comb begin
        bus.busy = (state_q == DRIVE);
        bus.done = (state_q == DONE);
        cnt_en   = (state_q == DRIVE);
        cnt_clr  = (state_q != DRIVE);
    end

    // Vector index, gate drive and result accumulation.
    always_comb begin
        idx_d  = idx_q;
        ab_d   = ab_q;
        err_d  = err_q;
        fv_d   = fv_q;
        pass_d = pass_q;
        if (launch) begin
            idx_d  = '0;
            ab_d   = '0;
            err_d  = '0;
            fv_d   = '0;
            pass_d = 1'b0;
        end else if (sample) begin
            if (mismatch) begin
                fv_d[idx_q] = 1'b1;
                err_d       = err_q + 3'd1;
            end
            if (last_vec) begin
                pass_d = (err_d == 3'd0);
                ab_d   = '0;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + 2'd1;
                ab_d  = idx_q + 2'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            ab_q   <= '0;
            err_q  <= '0;
            fv_q   <= '0;
            pass_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            ab_q   <= ab_d;
            err_q  <= err_d;
            fv_q   <= fv_d;
            pass_q <= pass_d;
        end
    end

    assign bus.o_a       = ab_q[1];
    assign bus.o_b       = ab_q[0];
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fv_q;
endmodule

// File: tb/tb_nor_stimulus_sequencer.sv
// Scoreboard bench for nor_stimulus_sequencer (default build, DWELL=4).
module tb_nor_stimulus_sequencer;
    localparam int DWELL = 4;
    localparam int CNT_W = 8;
    localparam int SWEEP = 4 * DWELL;

    typedef struct {
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nor_stimulus_sequencer_if ifc ();

    // Gate model: 0 = healthy NOR, 1 = c stuck at 0, 2 = c stuck at 1.
    int mode = 0;
    assign ifc.i_c = (mode == 0) ? ~(ifc.o_a | ifc.o_b) : ((mode == 1) ? 1'b0 : 1'b1);
`ifdef NOR_SEQ_LOOP_EN
    assign ifc.loop = 1'b0;
`endif

    nor_stimulus_sequencer #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int   checks = 0;
    int   failures = 0;
    int   k = 0;
    bit   active = 1'b0;
    res_t held = '{1'b0, 3'd0, 4'd0};
    res_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected sweep result for a given gate behaviour.
    function automatic res_t model(int m);
        res_t r;
        logic [1:0] v;
        logic good, c;
        r = '{1'b0, 3'd0, 4'd0};
        for (int i = 0; i < 4; i++) begin
            v    = 2'(i);
            good = ~(v[1] | v[0]);
            c    = (m == 0) ? good : ((m == 1) ? 1'b0 : 1'b1);
            if (c !== good) begin
                r.fv[i] = 1'b1;
                r.err   = r.err + 3'd1;
            end
        end
        r.pass = (r.err == 3'd0);
        return r;
    endfunction

    task automatic chk_results(input string tag, input res_t e);
        chk({tag, "_pass"}, 32'(ifc.pass), 32'(e.pass));
        chk({tag, "_err"}, 32'(ifc.err_count), 32'(e.err));
        chk({tag, "_fv"}, 32'(ifc.fail_vec), 32'(e.fv));
    endtask

    // Accepted start: record the capture edge and push the expected result.
    task automatic do_start();
        @(negedge clk);
        ifc.start = 1'b1;
        k = edge_n + 1;
        active = 1'b1;
        sb.push_back(model(mode));
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    // Start pulse the DUT must ignore (issued while busy or in DONE).
    task automatic stray_start();
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    // Per-cycle monitor, sampled on the falling edge.
    always @(negedge clk) begin : mon
        int d;
        bit in_drive, exp_done;
        if (rst_n === 1'b1) begin
            d        = active ? (edge_n - k) : -1;
            in_drive = (d >= 0) && (d < SWEEP);
            exp_done = (d == SWEEP);
            chk("busy", 32'(ifc.busy), 32'(in_drive));
            chk("done", 32'(ifc.done), 32'(exp_done));
            chk("ab", 32'({ifc.o_a, ifc.o_b}), in_drive ? 32'(d / DWELL) : 32'd0);
            if (in_drive) begin
                chk("pass_in_drive", 32'(ifc.pass), 32'd0);
            end else begin
                if (exp_done) begin
                    chk("sb_size", 32'(sb.size()), 32'd1);
                    if (sb.size() > 0) held = sb.pop_front();
                end
                chk_results(exp_done ? "done_res" : "idle_res", held);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        ifc.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_ab", 32'({ifc.o_a, ifc.o_b}), 32'd0);
        chk_results("rst", held);
        rst_n = 1'b1;

        // Healthy gate, then stuck-at-0, then stuck-at-1.
        for (int m = 0; m < 3; m++) begin
            mode = m;
            do_start();
            repeat (SWEEP + 3) @(negedge clk);
        end

        // Stray starts mid-sweep and during DONE are ignored.
        mode = 0;
        do_start();
        repeat (3) @(negedge clk);
        stray_start();
        while (edge_n < k + SWEEP - 1) @(negedge clk);
        stray_start();
        repeat (4) @(negedge clk);

        // Reset in the middle of a sweep, then a clean sweep.
        mode = 1;
        do_start();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(ifc.busy), 32'd0);
        chk("arst_done", 32'(ifc.done), 32'd0);
        chk("arst_ab", 32'({ifc.o_a, ifc.o_b}), 32'd0);
        chk("arst_pass", 32'(ifc.pass), 32'd0);
        chk("arst_err", 32'(ifc.err_count), 32'd0);
        chk("arst_fv", 32'(ifc.fail_vec), 32'd0);
        active = 1'b0;
        sb.delete();
        held = '{1'b0, 3'd0, 4'd0};
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        mode = 0;
        do_start();
        repeat (SWEEP + 3) @(negedge clk);

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
